// File: rtl/fp_ser_pkg.sv
// fp_ser_pkg: shared state encoding, flag positions and IEEE-754 constant helpers
// for the byte-serial floating-point multiplier.
package fp_ser_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, NORM, RND, OUT} state_t;
  localparam int F_INVALID   = 3;
  localparam int F_OVERFLOW  = 2;
  localparam int F_UNDERFLOW = 1;
  localparam int F_INEXACT   = 0;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [255:0] qnan(input int ew, input int fw);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[fw + i] = 1'b1;
    v[fw - 1] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/fp_seq_mul.sv
// fp_seq_mul: radix-2 shift-add significand multiplier, one multiplier bit per cycle.
// o_done is high during the final iteration, so o_prod is complete after that edge.
module fp_seq_mul #(
  parameter int N = 53
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_done,
  output logic [2*N-1:0] o_prod
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0]   r_a;
  logic [2*N-1:0] r_p;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     w_sum;
  assign w_sum  = {1'b0, r_p[2*N-1:N]} + {1'b0, (r_p[0] ? r_a : {N{1'b0}})};
  assign o_done = r_cnt == CW'(1);
  assign o_prod = r_p;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_p   <= {{N{1'b0}}, i_b};
      r_cnt <= CW'(N);
    end else if (r_cnt != '0) begin
      r_p   <= {w_sum, r_p[N-1:1]};
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/fp_mult_ser.sv
// fp_mult_ser: byte-serial IEEE-754 multiplier with RNE rounding, DAZ/FTZ and flags.
// Operands stream in MSB first (x then y), the product streams out over the same bus.
module fp_mult_ser
  import fp_ser_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int BUS_W  = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [BUS_W-1:0] DATA_IN,
  input  logic             ENABLE,
  output logic [BUS_W-1:0] DATA_OUT,
  output logic             READY,
  output logic [3:0]       FLAGS,
  output logic             BUSY
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int NB = W / BUS_W;
  localparam int N  = FRAC_W + 1;
  localparam int CW = $clog2(2 * NB + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0]          QNAN   = W'(qnan(EXP_W, FRAC_W));
  localparam logic signed [EW-1:0]  BIAS_S = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0]  EMAX   = EW'((1 << EXP_W) - 1);
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [2*W-1:0]          r_op;
  logic [W-1:0]            r_out;
  logic                    r_sign;
  logic signed [EW-1:0]    r_exp;
  logic [FRAC_W-1:0]       r_frac;
  logic                    r_g, r_r, r_s;
  logic                    r_spec;
  logic [W-1:0]            r_spec_res;
  logic [3:0]              r_spec_fl;
  logic [2*W-1:0]          w_op_nxt;
  logic                    w_last, w_done;
  logic [2*N-1:0]          w_prod;
  logic [EXP_W-1:0]        w_ex, w_ey;
  logic [FRAC_W-1:0]       w_fx, w_fy;
  logic                    w_sign;
  logic                    w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
  logic                    w_snan, w_nan, w_inv_mul, w_uf, w_spec;
  logic [W-1:0]            w_spec_res;
  logic [3:0]              w_spec_fl;
  logic                    w_msb;
  logic [FRAC_W-1:0]       w_nfrac;
  logic                    w_g, w_r, w_s;
  logic signed [EW-1:0]    w_nexp;
  logic                    w_up, w_carry, w_ovf, w_inx;
  logic [FRAC_W-1:0]       w_rfrac;
  logic signed [EW-1:0]    w_rexp;
  logic [W-1:0]            w_res;
  logic [3:0]              w_fl;
  assign BUSY     = r_state != IDLE;
  assign w_op_nxt = {r_op[2*W-BUS_W-1:0], DATA_IN};
  assign w_last   = (r_state == LOAD) && ENABLE && (r_cnt == CW'(2 * NB - 1));
  // The multiplier loads straight from the assembled operands on the final capture edge.
  fp_seq_mul #(.N(N)) u_mul (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_start (w_last),
    .i_a     ({1'b1, w_op_nxt[W+FRAC_W-1:W]}),
    .i_b     ({1'b1, w_op_nxt[FRAC_W-1:0]}),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );
  assign w_ex      = r_op[2*W-2 -: EXP_W];
  assign w_fx      = r_op[W+FRAC_W-1:W];
  assign w_ey      = r_op[W-2 -: EXP_W];
  assign w_fy      = r_op[FRAC_W-1:0];
  assign w_sign    = r_op[2*W-1] ^ r_op[W-1];
  assign w_x_zero  = w_ex == '0;
  assign w_y_zero  = w_ey == '0;
  assign w_x_nan   = (&w_ex) && (|w_fx);
  assign w_y_nan   = (&w_ey) && (|w_fy);
  assign w_x_inf   = (&w_ex) && !(|w_fx);
  assign w_y_inf   = (&w_ey) && !(|w_fy);
  assign w_snan    = (w_x_nan && !w_fx[FRAC_W-1]) || (w_y_nan && !w_fy[FRAC_W-1]);
  assign w_nan     = w_x_nan || w_y_nan;
  assign w_inv_mul = (w_x_inf && w_y_zero) || (w_y_inf && w_x_zero);
  assign w_msb     = w_prod[2*N-1];
  assign w_nfrac   = w_msb ? w_prod[2*FRAC_W:FRAC_W+1] : w_prod[2*FRAC_W-1:FRAC_W];
  assign w_g       = w_msb ? w_prod[FRAC_W]   : w_prod[FRAC_W-1];
  assign w_r       = w_msb ? w_prod[FRAC_W-1] : w_prod[FRAC_W-2];
  assign w_s       = w_msb ? |w_prod[FRAC_W-2:0] : |w_prod[FRAC_W-3:0];
  assign w_nexp    = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - BIAS_S
                   + $signed({{(EW-1){1'b0}}, w_msb});
  assign w_uf      = w_nexp <= 0;
  assign w_spec    = w_nan || w_x_inf || w_y_inf || w_x_zero || w_y_zero || w_uf;
  assign w_spec_res = (w_nan || w_inv_mul) ? QNAN :
                      (w_x_inf || w_y_inf) ? {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                                             {w_sign, {(W-1){1'b0}}};
  assign w_spec_fl  = (w_nan || w_inv_mul) ? {w_inv_mul || w_snan, 3'b000} :
                      (w_x_inf || w_y_inf || w_x_zero || w_y_zero) ? 4'b0000 :
                      4'((1 << F_UNDERFLOW) | (1 << F_INEXACT));
  assign w_up               = r_g && (r_r || r_s || r_frac[0]);
  assign {w_carry, w_rfrac} = {1'b0, r_frac} + {{FRAC_W{1'b0}}, w_up};
  assign w_rexp             = r_exp + $signed({{(EW-1){1'b0}}, w_carry});
  assign w_ovf              = w_rexp >= EMAX;
  assign w_inx              = r_g || r_r || r_s;
  assign w_res = r_spec ? r_spec_res :
                 w_ovf  ? {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                          {r_sign, w_rexp[EXP_W-1:0], w_rfrac};
  assign w_fl  = r_spec ? r_spec_fl :
                 w_ovf  ? 4'((1 << F_OVERFLOW) | (1 << F_INEXACT)) :
                          {3'b000, w_inx};
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_out      <= '0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_frac     <= '0;
      r_g        <= 1'b0;
      r_r        <= 1'b0;
      r_s        <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_spec_fl  <= '0;
      DATA_OUT   <= '0;
      READY      <= 1'b0;
      FLAGS      <= '0;
    end else begin
      case (r_state)
        IDLE: if (ENABLE) begin
          r_op    <= w_op_nxt;
          r_cnt   <= CW'(1);
          r_state <= LOAD;
        end
        LOAD: if (ENABLE) begin
          r_op    <= w_op_nxt;
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          r_state <= w_last ? MUL : LOAD;
        end
        MUL: if (w_done) r_state <= NORM;
        NORM: begin
          r_sign     <= w_sign;
          r_exp      <= w_nexp;
          r_frac     <= w_nfrac;
          r_g        <= w_g;
          r_r        <= w_r;
          r_s        <= w_s;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_fl  <= w_spec_fl;
          r_state    <= RND;
        end
        RND: begin
          DATA_OUT <= w_res[W-1 -: BUS_W];
          r_out    <= w_res << BUS_W;
          READY    <= 1'b1;
          FLAGS    <= w_fl;
          r_cnt    <= CW'(1);
          r_state  <= OUT;
        end
        OUT: if (r_cnt == CW'(NB)) begin
          DATA_OUT <= '0;
          READY    <= 1'b0;
          FLAGS    <= '0;
          r_cnt    <= '0;
          r_state  <= IDLE;
        end else begin
          DATA_OUT <= r_out[W-1 -: BUS_W];
          r_out    <= r_out << BUS_W;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult_ser.sv
// tb_fp_mult_ser: scoreboard bench driving a double- and a single-precision instance.
module tb_fp_mult_ser;
  typedef struct {logic [63:0] res; logic [3:0] fl;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       en_d = 1'b0, en_s = 1'b0;
  logic [7:0] dout_d, dout_s, dout;
  logic       rdy_d, rdy_s, rdy, busy_d, busy_s, busy;
  logic [3:0] fl_d, fl_s, fl;
  logic       sel_sp = 1'b0;
  int         cyc, last_cyc, n_chk, n_pass;
  exp_t       sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rdy  = sel_sp ? rdy_s  : rdy_d;
  assign dout = sel_sp ? dout_s : dout_d;
  assign busy = sel_sp ? busy_s : busy_d;
  assign fl   = sel_sp ? fl_s   : fl_d;
  fp_mult_ser u_dp (
    .CLK(clk), .RESET_N(rst_n), .DATA_IN(din), .ENABLE(en_d),
    .DATA_OUT(dout_d), .READY(rdy_d), .FLAGS(fl_d), .BUSY(busy_d)
  );
  fp_mult_ser #(.EXP_W(8), .FRAC_W(23), .BUS_W(8)) u_sp (
    .CLK(clk), .RESET_N(rst_n), .DATA_IN(din), .ENABLE(en_s),
    .DATA_OUT(dout_s), .READY(rdy_s), .FLAGS(fl_s), .BUSY(busy_s)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input bit v, input logic [7:0] d);
    if (sel_sp) en_s = v;
    else en_d = v;
    din = d;
  endtask
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [63:0] er,
                      input logic [3:0] ef, input logic [15:0] gaps, input bit junk);
    int nb = sel_sp ? 4 : 8;
    sb.push_back(exp_t'{er, ef});
    for (int i = 0; i < 2 * nb; i++) begin
      if (gaps[i]) begin
        @(negedge clk);
        drive(1'b0, 8'($urandom));
      end
      @(negedge clk);
      drive(1'b1, i < nb ? x[(nb-1-i)*8 +: 8] : y[(2*nb-1-i)*8 +: 8]);
    end
    @(negedge clk);
    last_cyc = cyc;
    drive(1'b0, 8'h00);
    if (junk) begin
      repeat (5) begin
        @(negedge clk);
        drive(1'b1, 8'($urandom));
      end
      @(negedge clk);
      drive(1'b0, 8'h00);
    end
  endtask
  task automatic wait_ready();
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!rdy && k < 300);
    check("ready_rise", 64'(rdy), 64'd1);
  endtask
  task automatic recv();
    int nb = sel_sp ? 4 : 8;
    int hi = 0;
    exp_t e;
    logic [63:0] got = '0;
    logic [3:0] f0, fl_last;
    e = sb.pop_front();
    wait_ready();
    check("latency", 64'(cyc - last_cyc), sel_sp ? 64'd26 : 64'd55);
    f0 = fl;
    fl_last = fl;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        @(posedge clk);
        #1;
      end
      hi += int'(rdy);
      got = {got[55:0], dout};
      fl_last = fl;
    end
    @(posedge clk);
    #1;
    check("result", got, e.res);
    check("flags", 64'(f0), 64'(e.fl));
    check("flags_held", 64'(fl_last), 64'(e.fl));
    check("ready_beats", 64'(hi), 64'(nb));
    check("ready_drop", 64'(rdy), 64'd0);
    check("dout_zero", 64'(dout), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask
  task automatic run(input logic [63:0] x, input logic [63:0] y, input logic [63:0] er,
                     input logic [3:0] ef, input logic [15:0] gaps);
    send(x, y, er, ef, gaps, 1'b0);
    recv();
  endtask
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(rdy), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    check("rst_dp", {rdy_d, dout_d, fl_d, busy_d}, '0);
    check("rst_sp", {rdy_s, dout_s, fl_s, busy_s}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    sel_sp = 1'b0;
    run(64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000, 16'h0000);
    run(64'h3FF8000000000000, 64'hBFF8000000000000, 64'hC002000000000000, 4'b0000, 16'h0884);
    run(64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1000, 16'h0000);
    run(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 4'b0101, 16'h0000);
    run(64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 4'b0001, 16'h0000);
    run(64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 4'b0011, 16'h0000);
    run(64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 4'b0001, 16'h0000);
    run(64'h3FF0000000000003, 64'h3FF8000000000000, 64'h3FF8000000000004, 4'b0001, 16'h0000);
    run(64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b1000, 16'h0000);
    run(64'h7FF8000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b0000, 16'h0000);
    run(64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 4'b0000, 16'h0000);
    run(64'h8000000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 4'b0000, 16'h0000);
    run(64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, 4'b0000, 16'h0000);
    sel_sp = 1'b1;
    send(64'h40000000, 64'h40400000, 64'h40C00000, 4'b0000, 16'h0000, 1'b1);
    recv();
    send(64'h3FC00000, 64'h3FC00000, 64'h40100000, 4'b0000, 16'h0000, 1'b0);
    recv();
    sel_sp = 1'b0;
    send(64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000, 16'h0000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("busy_mul", 64'(busy), 64'd1);
    async_reset();
    run(64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000, 16'h0000);
    send(64'h3FF8000000000000, 64'hBFF8000000000000, 64'hC002000000000000, 4'b0000, 16'h0000, 1'b0);
    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    check("ready_beat3", 64'(rdy), 64'd1);
    async_reset();
    run(64'h3FF8000000000000, 64'hBFF8000000000000, 64'hC002000000000000, 4'b0000, 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_mult_ser.md
Name: fp_mult_ser

Overview:
Parametrised byte-serial IEEE-754 multiplier; successor to the fixed double-precision fp_mult. Streams two operands in over a narrow bus and computes the product with a sequential shift-add mantissa multiplier, round-to-nearest-even and exception flags. It then streams the result out over the same bus width. Unlike fp_mult, it accepts gapped input beats, runs back-to-back operations without reset, and reports IEEE flags.

Parameters:
EXP_W, 11, exponent field width (8 for single precision).
FRAC_W, 52, fraction field width (23 for single precision).
BUS_W, 8, serial bus width. W=1+EXP_W+FRAC_W must be a multiple of BUS_W; NB=W/BUS_W beats per operand.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
DATA_IN  in  BUS_W  input beat.
ENABLE  in  1  DATA_IN valid this cycle.
DATA_OUT  out  BUS_W  result beat.
READY  out  1  DATA_OUT valid this cycle.
FLAGS  out  4  {INVALID, OVERFLOW, UNDERFLOW, INEXACT}; valid while READY.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, beat counter 0, DATA_OUT=0, READY=0, FLAGS=0, BUSY=0. Reset mid-operation abandons the operation immediately.
- States: IDLE -> LOAD -> MUL -> NORM -> RND -> OUT -> IDLE.
- IDLE: the first edge with ENABLE=1 captures beat 0 and moves to LOAD.
- LOAD: each edge with ENABLE=1 captures one beat. Beats 0..NB-1 form x and beats NB..2NB-1 form y, MSB first. Edges with ENABLE=0 are gaps: no capture and no count change. Capturing beat 2NB-1 moves to MUL.
- MUL: 1-bit-per-cycle shift-add over (FRAC_W+1)-bit significands; lasts FRAC_W+1 cycles and produces a 2(FRAC_W+1)-bit product. Sign = sx XOR sy.
- NORM, 1 cycle:
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - Biased exponent = ex + ey - BIAS (+1 on that shift), carried in EXP_W+2 signed bits.
  - Form guard, round and sticky bits.
- RND, 1 cycle:
  - Round to nearest, ties to even. A carry-out of the fraction increments the exponent.
  - INEXACT = G|R|S.
- READY first rises FRAC_W+3 edges after the edge that captures the last input beat.
- OUT:
  - READY is high for exactly NB consecutive cycles; DATA_OUT carries the result MSB first, one beat per cycle.
  - FLAGS is held for the whole burst.
  - After the last beat: READY=0, DATA_OUT=0, state IDLE.
  - The next operation may start on the following edge.
- ENABLE is ignored in MUL, NORM, RND and OUT; those beats are dropped, not queued.
- Special cases are resolved in NORM and bypass rounding:
  - Subnormal inputs are treated as zero (DAZ).
  - Any NaN input, or inf*0: result is canonical qNaN (sign 0, exponent all ones, fraction MSB=1, rest 0). INVALID is set for inf*0 or any signalling NaN.
  - inf*nonzero finite: signed inf, no flags.
  - zero*finite: signed zero, no flags.
- Overflow (rounded exponent >= 2^EXP_W-1): signed inf, OVERFLOW|INEXACT.
- Underflow (pre-round exponent <= 0): signed zero (FTZ), UNDERFLOW|INEXACT.
- Only the result is exported. The FLAGS bit order is fixed: [3]=INVALID, [2]=OVERFLOW, [1]=UNDERFLOW, [0]=INEXACT.

Decomposition:
- Package fp_ser_pkg holds:
  - state encoding: IDLE, LOAD, MUL, NORM, RND, OUT;
  - flag bit indices;
  - BIAS = 2^(EXP_W-1)-1 as a function of EXP_W;
  - a canonical-qNaN constant function.
- Sub-module fp_seq_mul: the shift-add significand multiplier. It has start, done, and a 2(FRAC_W+1)-bit product.
- Classification, normalise, round and the serialiser stay in fp_mult_ser.

Test Plan:
- Double, x=4000000000000000 (2.0), y=4008000000000000 (3.0), contiguous ENABLE -> 4018000000000000, FLAGS=0000; READY for exactly 8 cycles, first rise 55 edges after the last input edge.
- Double, 3FF8000000000000 * BFF8000000000000 with 3 idle ENABLE=0 gaps inserted in LOAD -> C002000000000000, FLAGS=0000. Gaps must not shift the beat alignment.
- Double, 7FF0000000000000 * 0000000000000000 -> 7FF8000000000000, FLAGS=1000. Also 7FEFFFFFFFFFFFFF * 4000000000000000 -> 7FF0000000000000, FLAGS=0101.
- Double, 3FF0000000000001 * 3FF0000000000001 -> 3FF0000000000002, FLAGS=0001 (2^-104 term rounds down). Also 0010000000000000 * 3FE0000000000000 -> 0000000000000000, FLAGS=0011.
- Single (EXP_W=8, FRAC_W=23), 40000000 * 40400000 -> 40C00000. Run two operations back-to-back with no reset; both results are correct and READY is high for exactly 4 cycles each.
- Reset handling: drive RESET_N=0 mid-MUL and again during the 3rd OUT beat; READY, DATA_OUT and BUSY drop to 0 without waiting for a clock edge. The next operation after reset release gives the correct result.
